// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake, synchronous flush, NOP bubbles.
// Define PIPE_STAGE_SKID_EN to add a second skid entry and a registered in_ready.
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              in_xfer;
    logic              out_xfer;
    logic              main_valid;
    logic              main_valid_d;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] main_data_d;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic              skid_valid_d;
    logic [DATA_W-1:0] skid_data;
    logic [DATA_W-1:0] skid_data_d;
    logic              ready_q;

    // in_ready is only low while the skid entry is occupied, which blocks in_xfer then.
    always_comb begin
        main_valid_d = main_valid;
        main_data_d  = main_data;
        skid_valid_d = skid_valid;
        skid_data_d  = skid_data;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = RESET_VAL;
            skid_valid_d = 1'b0;
            skid_data_d  = RESET_VAL;
        end else if (skid_valid) begin
            if (out_xfer) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data;
                skid_valid_d = 1'b0;
                skid_data_d  = RESET_VAL;
            end
        end else if (in_xfer) begin
            if (main_valid && !out_ready) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
            main_data_d  = RESET_VAL;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            skid_valid <= 1'b0;
            skid_data  <= RESET_VAL;
            ready_q    <= 1'b1;
        end else begin
            skid_valid <= skid_valid_d;
            skid_data  <= skid_data_d;
            ready_q    <= ~skid_valid_d;
        end
    end

    assign in_ready  = ready_q;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
`else
    assign in_ready = out_ready | ~main_valid;

    always_comb begin
        main_valid_d = main_valid;
        main_data_d  = main_data;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = RESET_VAL;
        end else if (in_xfer) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
            main_data_d  = RESET_VAL;
        end
    end

    assign occupancy = {1'b0, main_valid};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= RESET_VAL;
        end else begin
            main_valid <= main_valid_d;
            main_data  <= main_data_d;
        end
    end

endmodule
